alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 26 ++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer_alu_core.sv | 75 +++++++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and state definitions for the ALU sequencer and its single-cycle core.
package alu_sequencer_pkg;

    localparam int unsigned OPERAND_W = 8;

    localparam logic [4:0] ALU_ADD   = 5'h00;
    localparam logic [4:0] ALU_ADDC  = 5'h01;
    localparam logic [4:0] ALU_SUBB  = 5'h02;
    localparam logic [4:0] ALU_INC   = 5'h03;
    localparam logic [4:0] ALU_ANL   = 5'h04;
    localparam logic [4:0] ALU_ORL   = 5'h05;
    localparam logic [4:0] ALU_XRL   = 5'h06;
    localparam logic [4:0] ALU_CPL   = 5'h07;
    localparam logic [4:0] ALU_ANL_C = 5'h08;
    localparam logic [4:0] ALU_ORL_C = 5'h09;
    localparam logic [4:0] ALU_MUL   = 5'h0A;
    localparam logic [4:0] ALU_DIV   = 5'h0B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between a requester (master) and the sequencer (slave).
interface alu_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cy;
    logic       req_ac;
    logic       req_bit;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_lo;
    logic [7:0] rsp_hi;
    logic       rsp_cy;
    logic       rsp_ac;
    logic       rsp_ov;
    logic       busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cy, req_ac, req_bit, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cy, rsp_ac, rsp_ov, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cy, req_ac, req_bit, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cy, rsp_ac, rsp_ov, busy
    );

endinterface

// File: rtl/alu_sequencer_alu_core.sv
// Combinational single-cycle ALU: arithmetic, logic and carry-bit operations.
module alu_core
    import alu_sequencer_pkg::*;
(
    input  logic [4:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cy,
    input  logic       ac,
    input  logic       bit_op,
    output logic [7:0] res_lo,
    output logic [7:0] res_hi,
    output logic       res_cy,
    output logic       res_ac,
    output logic       res_ov
);

    logic [8:0]  sum9;
    logic [4:0]  nib5;
    logic [15:0] inc16;
    logic        cin;

    // Opcode decode; unknown opcodes fall through to an all-zero result.
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        res_cy = 1'b0;
        res_ac = 1'b0;
        res_ov = 1'b0;
        sum9   = '0;
        nib5   = '0;
        inc16  = '0;
        cin    = 1'b0;
        case (op)
            ALU_ADD, ALU_ADDC: begin
                cin    = (op == ALU_ADDC) ? cy : 1'b0;
                sum9   = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                nib5   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
                res_lo = sum9[7:0];
                res_cy = sum9[8];
                res_ac = nib5[4];
                res_ov = (a[7] == b[7]) && (sum9[7] != a[7]);
            end
            ALU_SUBB: begin
                sum9   = {1'b0, a} - {1'b0, b} - {8'b0, cy};
                nib5   = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cy};
                res_lo = sum9[7:0];
                res_cy = sum9[8];
                res_ac = nib5[4];
                res_ov = (a[7] != b[7]) && (sum9[7] != a[7]);
            end
            ALU_INC: begin
                inc16  = {b, a} + 16'd1;
                res_lo = inc16[7:0];
                res_hi = inc16[15:8];
                res_cy = cy;
                res_ac = ac;
            end
            ALU_ANL, ALU_ORL, ALU_XRL, ALU_CPL: begin
                res_lo = (op == ALU_ANL) ? (a & b) :
                         (op == ALU_ORL) ? (a | b) :
                         (op == ALU_XRL) ? (a ^ b) : ~a;
                res_cy = cy;
                res_ac = ac;
            end
            ALU_ANL_C, ALU_ORL_C: begin
                res_lo = a;
                res_cy = (op == ALU_ANL_C) ? (cy & bit_op) : (cy | bit_op);
                res_ac = ac;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer: single-cycle ops via alu_core, iterative MUL/DIV inline.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned MULDIV_ITERS = 8
) (
    input  logic           clock,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam logic [3:0] ITER_LAST = 4'(MULDIV_ITERS);

    seq_state_t state;
    logic [3:0] iter_cnt;
    logic [4:0] op_r;
    logic [7:0] a_r, b_r;
    logic       cy_r, ac_r, bit_r;
    logic [7:0] work_hi, work_lo;
    logic       req_ready_r, busy_r, rsp_valid_r;
    logic [7:0] rsp_lo_r, rsp_hi_r;
    logic       rsp_cy_r, rsp_ac_r, rsp_ov_r;

    logic [7:0] core_lo, core_hi;
    logic       core_cy, core_ac, core_ov;
    logic [8:0] mul_sum, div_shift;
    logic       div_fits;
    logic [7:0] iter_hi, iter_lo;

    alu_core u_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .cy     (cy_r),
        .ac     (ac_r),
        .bit_op (bit_r),
        .res_lo (core_lo),
        .res_hi (core_hi),
        .res_cy (core_cy),
        .res_ac (core_ac),
        .res_ov (core_ov)
    );

    // One MUL/DIV step: MUL is right-shifting shift-add with the multiplier in work_lo,
    // DIV is restoring division with remainder in work_hi and dividend/quotient in work_lo.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_r} : 9'd0);
        div_shift = {work_hi, work_lo[7]};
        div_fits  = (div_shift >= {1'b0, b_r});
        if (op_r == ALU_MUL) begin
            iter_hi = mul_sum[8:1];
            iter_lo = {mul_sum[0], work_lo[7:1]};
        end else begin
            iter_hi = div_fits ? 8'(div_shift - {1'b0, b_r}) : div_shift[7:0];
            iter_lo = {work_lo[6:0], div_fits};
        end
    end

    // Sequencer FSM with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            iter_cnt    <= '0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cy_r        <= 1'b0;
            ac_r        <= 1'b0;
            bit_r       <= 1'b0;
            work_hi     <= '0;
            work_lo     <= '0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_lo_r    <= '0;
            rsp_hi_r    <= '0;
            rsp_cy_r    <= 1'b0;
            rsp_ac_r    <= 1'b0;
            rsp_ov_r    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        op_r        <= bus.req_op;
                        a_r         <= bus.req_a;
                        b_r         <= bus.req_b;
                        cy_r        <= bus.req_cy;
                        ac_r        <= bus.req_ac;
                        bit_r       <= bus.req_bit;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        iter_cnt    <= '0;
                        work_hi     <= '0;
                        work_lo     <= (bus.req_op == ALU_MUL) ? bus.req_b : bus.req_a;
                        if ((bus.req_op == ALU_MUL || bus.req_op == ALU_DIV) && bus.req_b != 8'h00)
                            state <= ST_ITER;
                        else if (bus.req_op == ALU_DIV)
                            state <= ST_DONE;
                        else
                            state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // MUL only lands here with B==0: the product is zero and AC passes through.
                    if (op_r == ALU_MUL) begin
                        rsp_lo_r <= '0;
                        rsp_hi_r <= '0;
                        rsp_cy_r <= 1'b0;
                        rsp_ac_r <= ac_r;
                        rsp_ov_r <= 1'b0;
                    end else begin
                        rsp_lo_r <= core_lo;
                        rsp_hi_r <= core_hi;
                        rsp_cy_r <= core_cy;
                        rsp_ac_r <= core_ac;
                        rsp_ov_r <= core_ov;
                    end
                    rsp_valid_r <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_ITER: begin
                    if (iter_cnt == ITER_LAST) begin
                        rsp_lo_r    <= work_lo;
                        rsp_hi_r    <= work_hi;
                        rsp_cy_r    <= 1'b0;
                        rsp_ac_r    <= ac_r;
                        rsp_ov_r    <= (op_r == ALU_MUL) ? (work_hi != 8'h00) : 1'b0;
                        rsp_valid_r <= 1'b1;
                        iter_cnt    <= '0;
                        state       <= ST_DONE;
                    end else begin
                        work_hi  <= iter_hi;
                        work_lo  <= iter_lo;
                        iter_cnt <= iter_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // Divide-by-zero enters DONE straight from IDLE with no response yet;
                    // filling it here keeps its latency equal to the single-cycle path.
                    if (!rsp_valid_r) begin
                        rsp_lo_r    <= 8'hFF;
                        rsp_hi_r    <= a_r;
                        rsp_cy_r    <= 1'b0;
                        rsp_ac_r    <= ac_r;
                        rsp_ov_r    <= 1'b1;
                        rsp_valid_r <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_lo    = rsp_lo_r;
    assign bus.rsp_hi    = rsp_hi_r;
    assign bus.rsp_cy    = rsp_cy_r;
    assign bus.rsp_ac    = rsp_ac_r;
    assign bus.rsp_ov    = rsp_ov_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, scoreboard, corner-case sequences.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       cy;
        logic       ac;
        logic       ov;
    } res_t;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cy;
        logic       ac;
        logic       bt;
        res_t       exp;
        int         lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    res_t mon_e;
    vec_t tbl[$];

    alu_sequencer_if bus();

    alu_sequencer #(.MULDIV_ITERS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t rsp_now();
        return {bus.rsp_lo, bus.rsp_hi, bus.rsp_cy, bus.rsp_ac, bus.rsp_ov};
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic cy, input logic ac, input logic bt,
                                input logic [7:0] lo, input logic [7:0] hi,
                                input logic ecy, input logic eac, input logic eov, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cy = cy; v.ac = ac; v.bt = bt;
        v.exp = {lo, hi, ecy, eac, eov};
        v.lat = lat;
        return v;
    endfunction

    // Integer reference model of the response.
    function automatic res_t model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cy, input logic ac, input logic bt);
        res_t r;
        int ua, ub, sa, sb, ci, s, ss;
        r  = '0;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = 0;
        case (op)
            ALU_ADD, ALU_ADDC: begin
                ci   = (op == ALU_ADDC) ? int'(cy) : 0;
                s    = ua + ub + ci;
                ss   = sa + sb + ci;
                r.lo = 8'(s);
                r.cy = (s > 255);
                r.ac = ((ua % 16) + (ub % 16) + ci) > 15;
                r.ov = (ss > 127) || (ss < -128);
            end
            ALU_SUBB: begin
                ci   = int'(cy);
                s    = ua - ub - ci;
                ss   = sa - sb - ci;
                r.lo = 8'(s);
                r.cy = (s < 0);
                r.ac = ((ua % 16) - (ub % 16) - ci) < 0;
                r.ov = (ss > 127) || (ss < -128);
            end
            ALU_INC: begin
                s    = ub * 256 + ua + 1;
                r.lo = 8'(s);
                r.hi = 8'(s / 256);
                r.cy = cy;
                r.ac = ac;
            end
            ALU_ANL: begin r.lo = a & b; r.cy = cy; r.ac = ac; end
            ALU_ORL: begin r.lo = a | b; r.cy = cy; r.ac = ac; end
            ALU_XRL: begin r.lo = a ^ b; r.cy = cy; r.ac = ac; end
            ALU_CPL: begin r.lo = ~a;    r.cy = cy; r.ac = ac; end
            ALU_ANL_C: begin r.lo = a; r.cy = cy & bt; r.ac = ac; end
            ALU_ORL_C: begin r.lo = a; r.cy = cy | bt; r.ac = ac; end
            ALU_MUL: begin
                s    = ua * ub;
                r.lo = 8'(s);
                r.hi = 8'(s / 256);
                r.ov = (s > 255);
                r.ac = ac;
            end
            ALU_DIV: begin
                r.ac = ac;
                if (ub == 0) begin
                    r.lo = 8'hFF;
                    r.hi = a;
                    r.ov = 1'b1;
                end else begin
                    r.lo = 8'(ua / ub);
                    r.hi = 8'(ua % ub);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Scoreboard: compare each response on the negedge before its consuming edge.
    always @(negedge clock) begin
        if (!reset && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got %0h expected no response", rsp_now());
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp", 32'(rsp_now()), 32'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input vec_t v, input bit track);
        int guard;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 40) begin
            @(posedge clock); #1;
            guard++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_cy    = v.cy;
        bus.req_ac    = v.ac;
        bus.req_bit   = v.bt;
        bus.req_valid = 1'b1;
        if (track) exp_q.push_back(v.exp);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        // Scramble inputs while busy: the registered operands must be used.
        bus.req_op  = 5'($urandom);
        bus.req_a   = 8'($urandom);
        bus.req_b   = 8'($urandom);
        bus.req_cy  = 1'($urandom);
        bus.req_ac  = 1'($urandom);
        bus.req_bit = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 40);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        issue(v, 1'b1);
        check({tag, "_busy"}, 32'({bus.busy, bus.req_ready}), 32'b10);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t v;
        int   lat;
        bit   seen;
        logic [4:0] ops [13];
        ops = '{ALU_ADD, ALU_ADDC, ALU_SUBB, ALU_INC, ALU_ANL, ALU_ORL, ALU_XRL,
                ALU_CPL, ALU_ANL_C, ALU_ORL_C, ALU_MUL, ALU_DIV, 5'h1F};

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cy    = 1'b0;
        bus.req_ac    = 1'b0;
        bus.req_bit   = 1'b0;
        bus.rsp_ready = 1'b1;

        //                op         a      b      cy ac bt  lo     hi     cy ac ov lat
        tbl.push_back(mk(ALU_ADD,   8'h3A, 8'h0C, 0, 0, 0, 8'h46, 8'h00, 0, 1, 0, 2));
        tbl.push_back(mk(ALU_MUL,   8'h50, 8'hA0, 0, 1, 0, 8'h00, 8'h32, 0, 1, 1, 10));
        tbl.push_back(mk(ALU_DIV,   8'hFB, 8'h12, 0, 0, 0, 8'h0D, 8'h11, 0, 0, 0, 10));
        tbl.push_back(mk(ALU_DIV,   8'h77, 8'h00, 1, 1, 0, 8'hFF, 8'h77, 0, 1, 1, 2));
        tbl.push_back(mk(ALU_ADDC,  8'h7F, 8'h00, 1, 0, 0, 8'h80, 8'h00, 0, 1, 1, 2));
        tbl.push_back(mk(ALU_SUBB,  8'h00, 8'h01, 0, 0, 0, 8'hFF, 8'h00, 1, 1, 0, 2));
        tbl.push_back(mk(ALU_SUBB,  8'h80, 8'h01, 0, 0, 0, 8'h7F, 8'h00, 0, 1, 1, 2));
        tbl.push_back(mk(ALU_INC,   8'hFF, 8'h12, 1, 0, 0, 8'h00, 8'h13, 1, 0, 0, 2));
        tbl.push_back(mk(ALU_INC,   8'hFF, 8'hFF, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 2));
        tbl.push_back(mk(ALU_MUL,   8'hFF, 8'hFF, 1, 0, 0, 8'h01, 8'hFE, 0, 0, 1, 10));
        tbl.push_back(mk(ALU_MUL,   8'h0F, 8'h11, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 10));
        tbl.push_back(mk(ALU_MUL,   8'h5A, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0, 2));
        tbl.push_back(mk(ALU_DIV,   8'h05, 8'h07, 0, 1, 0, 8'h00, 8'h05, 0, 1, 0, 10));
        tbl.push_back(mk(ALU_DIV,   8'hFF, 8'h01, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 10));
        tbl.push_back(mk(5'h1F,     8'h12, 8'h34, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 2));
        tbl.push_back(mk(ALU_ANL_C, 8'h5A, 8'h00, 1, 1, 0, 8'h5A, 8'h00, 0, 1, 0, 2));
        tbl.push_back(mk(ALU_XRL,   8'hA5, 8'hFF, 1, 0, 0, 8'h5A, 8'h00, 1, 0, 0, 2));

        // Reset with a request pending: reset wins, nothing is accepted.
        repeat (2) @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = ALU_ADD;
        @(posedge clock); #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp", 32'(rsp_now()), 32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_busy", 32'(bus.busy), 32'd0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: response held stable for 5 cycles, then exactly one transfer.
        bus.rsp_ready = 1'b0;
        v = tbl[0];
        issue(v, 1'b1);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_hold", 32'(rsp_now()), 32'(v.exp));
            check("bp_valid_ready", 32'({bus.rsp_valid, bus.req_ready}), 32'b10);
        end
        @(posedge clock); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_consumed", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        check("bp_single", 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;

        // Reset at ITER cycle 4 of a MUL: aborted, no response follows.
        issue(tbl[1], 1'b0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_rsp", 32'(rsp_now()), 32'd0);
        check("abort_flags", 32'({bus.rsp_valid, bus.busy, bus.req_ready}), 32'b001);
        seen = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        @(posedge clock); #1;
        run_vec(tbl[0], "after_abort");

        // Random vectors against the reference model.
        for (int n = 0; n < 24; n++) begin
            v.op = ops[$urandom_range(0, 12)];
            v.a  = 8'($urandom);
            v.b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            v.cy = 1'($urandom);
            v.ac = 1'($urandom);
            v.bt = 1'($urandom);
            v.exp = model(v.op, v.a, v.b, v.cy, v.ac, v.bt);
            v.lat = ((v.op == ALU_MUL || v.op == ALU_DIV) && v.b != 8'h00) ? 10 : 2;
            run_vec(v, $sformatf("rnd%0d", n));
        end

        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
